// File: rtl/tekst_pkg.sv
// tekst_pkg: constants shared by the text-scroll controller front end
package tekst_pkg;
  localparam int CLK_HZ = 24_000_000;
  localparam int DEB_CYCLES_DFLT = CLK_HZ / 100;
  localparam int BTN_PAUSE   = 0;
  localparam int BTN_REVERSE = 1;
  localparam int BTN_FASTER  = 2;
  localparam int BTN_SLOWER  = 3;
  localparam int BTN_LONGER  = 4;
  localparam int BTN_SHORTER = 5;
  typedef enum logic [1:0] {
    S_LO       = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HI       = 2'd2,
    S_FALL_CHK = 2'd3
  } deb_state_e;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/button_debounce_if.sv
// button_debounce_if: raw button pins in, debounced levels and strobes out
interface button_debounce_if #(
  parameter int N_BTN = 6
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;
  modport master (output btn_raw, input btn_level, btn_rise, btn_fall);
  modport slave (input btn_raw, output btn_level, btn_rise, btn_fall);
endinterface

// File: rtl/button_debounce_ch.sv
// debounce_ch: one channel - 2-FF synchroniser, debounce FSM, optional auto-repeat (BUTTON_DEBOUNCE_REPEAT_EN)
module debounce_ch
  import tekst_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DFLT,
  parameter int CNT_W      = 18
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 12_000_000,
  parameter int REPEAT_PERIOD = 4_800_000,
  parameter bit REPEAT_ON     = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic sync1_q, sync2_q;
  deb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d, rise_q, rise_d, fall_q, fall_d;
  logic done, rep;
  assign done = cnt_q == CNT_W'(DEB_CYCLES - 1);
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int RCW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic rnext_q, rnext_d, stay;
  // rnext_q selects the period once the first (longer) delay has fired
  always_comb begin
    stay    = state_q == S_HI && sync2_q;
    rep     = REPEAT_ON && stay &&
              rcnt_q == (rnext_q ? RCW'(REPEAT_PERIOD - 1) : RCW'(REPEAT_DELAY - 1));
    rcnt_d  = (!stay || rep) ? '0 : rcnt_q + 1'b1;
    rnext_d = !stay ? 1'b0 : (rep ? 1'b1 : rnext_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q  <= '0;
      rnext_q <= 1'b0;
    end else begin
      rcnt_q  <= rcnt_d;
      rnext_q <= rnext_d;
    end
  end
`else
  assign rep = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = rep;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LO: if (sync2_q) begin
        state_d = S_RISE_CHK;
        cnt_d   = CNT_W'(1);
      end
      S_RISE_CHK: if (!sync2_q) state_d = S_LO;
      else if (done) begin
        state_d = S_HI;
        level_d = 1'b1;
        rise_d  = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      S_HI: if (!sync2_q) begin
        state_d = S_FALL_CHK;
        cnt_d   = CNT_W'(1);
      end
      S_FALL_CHK: if (sync2_q) state_d = S_HI;
      else if (done) begin
        state_d = S_LO;
        level_d = 1'b0;
        fall_d  = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = S_LO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= S_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end
  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/button_debounce.sv
// button_debounce: N_BTN independent debounced channels; auto-repeat under BUTTON_DEBOUNCE_REPEAT_EN
module button_debounce
  import tekst_pkg::*;
#(
  parameter int               N_BTN         = 6,
  parameter int               DEB_CYCLES    = DEB_CYCLES_DFLT,
  parameter int               CNT_W         = 18,
  parameter int               REPEAT_DELAY  = 12_000_000,
  parameter int               REPEAT_PERIOD = 4_800_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 6'b001100
) (
  input logic              clk,
  input logic              rst,
  button_debounce_if.slave btn_if
);
  logic [N_BTN-1:0] level, rise, fall;
  if (DEB_CYCLES < 2 || 2 ** CNT_W <= DEB_CYCLES || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      $bits(REPEAT_MASK) != N_BTN) begin : g_bad_cfg
    $error("button_debounce: invalid parameter set");
  end
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_ON    (REPEAT_MASK[i])
`endif
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (btn_if.btn_raw[i]),
      .level_o(level[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end
  assign btn_if.btn_level = level;
  assign btn_if.btn_rise  = rise;
  assign btn_if.btn_fall  = fall;
endmodule
